// File: rtl/bus_arbiter2_pkg.sv
// Shared types and constants for the two-requester burst arbiter.
// Holds the FSM state encoding, default data width and beat-counter width.
package bus_arbiter2_pkg;

    localparam int DW_DEF = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/bus_arbiter2_if.sv
// Requester/downstream bundle of the two-requester arbiter.
// master = environment side, slave = arbiter side.
interface bus_arbiter2_if
    import bus_arbiter2_pkg::*;
#(
    parameter int DW = DW_DEF
);

    logic          req0;
    logic [DW-1:0] data0;
    logic          req1;
    logic [DW-1:0] data1;
    logic          gnt0;
    logic          gnt1;
    logic          sel;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output req0, data0, req1, data1, out_ready,
        input  gnt0, gnt1, sel, out_data, out_valid
    );

    modport slave (
        input  req0, data0, req1, data1, out_ready,
        output gnt0, gnt1, sel, out_data, out_valid
    );

endinterface

// File: rtl/mux2to1.sv
// Plain 2:1 data multiplexer, 8 bits wide by default.
module mux2to1 #(
    parameter int W = 8
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel0,
    output logic [W-1:0] y
);

    assign y = sel0 ? in1 : in0;

endmodule

// File: rtl/bus_arbiter2.sv
// Two-requester burst arbiter: registered grants, bounded bursts,
// alternation on ties and at burst end, combinational data mux.
module bus_arbiter2
    import bus_arbiter2_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int DW        = DW_DEF
) (
    input logic           clk,
    input logic           rst,
    bus_arbiter2_if.slave bus
);

    localparam cnt_t LAST_BEAT = cnt_t'(MAX_BURST - 1);

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   last_q, last_d;
    logic   sel_q, sel_d;

    logic gnt0_s, gnt1_s, valid_s, xfer_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    assign xfer_s = valid_s & bus.out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (bus.req0) begin
                    state_d = OWN0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    state_d = bus.req1 ? OWN1 : IDLE;
                end else if (xfer_s) begin
                    if (cnt_q == LAST_BEAT) begin
                        if (bus.req1) state_d = OWN1;
                        else          cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? OWN0 : IDLE;
                end else if (xfer_s) begin
                    if (cnt_q == LAST_BEAT) begin
                        if (bus.req0) state_d = OWN0;
                        else          cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        // IDLE keeps the previous select and owner history
        if (state_d == OWN0) begin
            sel_d  = 1'b0;
            last_d = 1'b0;
        end else if (state_d == OWN1) begin
            sel_d  = 1'b1;
            last_d = 1'b1;
        end
    end

    always_comb begin
        gnt0_s  = (state_q == OWN0);
        gnt1_s  = (state_q == OWN1);
        valid_s = (gnt0_s & bus.req0) | (gnt1_s & bus.req1);
    end

    assign bus.gnt0      = gnt0_s;
    assign bus.gnt1      = gnt1_s;
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid_s;

    mux2to1 #(
        .W(DW)
    ) u_mux (
        .in0 (bus.data0),
        .in1 (bus.data1),
        .sel0(sel_q),
        .y   (bus.out_data)
    );

endmodule
